bypass_scoreboard: RTL
======================

Name: bypass_scoreboard

Overview:
- Parametrised operand-bypass network combined with a per-register pending-write scoreboard for the pipelined MIPS core.
- Sits beside decode/issue. For each of NREAD source operands it selects the youngest matching in-flight result from NSTAGE forwarding stages, or the register-file value.
- Tracks multi-cycle producers (loads, multiply) with per-register countdown counters and raises stall when an operand's result is not yet forwardable, or when a write-after-write hazard exists.

Parameters:
- NREAD, 2, number of source operands checked per issued instruction
- NSTAGE, 3, number of forwarding stages; index 0 is the youngest (EX)
- MAXLAT, 4, maximum producer latency in cycles
- DW, 32, data width
- AW, 5, register address width
- LW, $clog2(MAXLAT+1), latency field width
- SW, $clog2(NSTAGE+1), select field width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- issue_valid  in  1  instruction is issuing this cycle
- issue_wen  in  1  issuing instruction writes a register
- issue_dest  in  AW  destination register
- issue_lat  in  LW  producer latency in cycles
- flush  in  1  squash all pending scoreboard entries
- stage_wen  in  NSTAGE  per-stage writeback enable
- stage_dest  in  NSTAGE*AW  per-stage destination
- stage_data  in  NSTAGE*DW  per-stage result
- src_reg  in  NREAD*AW  source register numbers
- src_rdat  in  NREAD*DW  register-file read data
- src_data  out  NREAD*DW  forwarded operand values
- src_sel  out  NREAD*SW  0 = register file, k+1 = stage k, per operand
- stall  out  1  hold the issuing instruction
- stall_src  out  NREAD  one-hot per operand: stalled on RAW
- stall_waw  out  1  stalled on WAW
- stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Scoreboard: cnt[r] of width LW for r = 1 to 2^AW-1. cnt[0] is hardwired to 0.
- Reset (asynchronous, RST=1): all cnt cleared to 0 and stall_cycles set to 0. The combinational outputs follow from this: stall=0, stall_src=0, stall_waw=0.
- Latency normalisation:
  - eff_lat = issue_lat clamped to the range [1, MAXLAT].
  - 0 is treated as 1.
  - Values above MAXLAT are treated as MAXLAT.
- RAW stall:
  - stall_src[i] = (src_reg[i] != 0) and (cnt[src_reg[i]] != 0).
  - The check uses current (pre-update) counters, so a self-dependency such as r1 <- r1 op r1 checks the older producer.
- WAW stall:
  - stall_waw = issue_valid and issue_wen and (issue_dest != 0) and (cnt[issue_dest] > eff_lat-1).
  - This prevents a shorter op from being clobbered later by an older, longer one.
- stall = issue_valid and (|stall_src or stall_waw). Stall is combinational and is masked to 0 when issue_valid=0.
- Accepted issue = issue_valid and not stall.
- Per-edge counter update, in priority order:
  - flush: all cnt <= 0; flush wins over any same-cycle issue.
  - Accepted issue with issue_wen and dest != 0: cnt[dest] <= eff_lat-1.
  - All other nonzero cnt decrement by 1; a zero cnt stays at 0.
  - An issue to register r overrides r's decrement in that cycle.
- Latency examples:
  - ALU (lat=1): cnt stays 0, so a back-to-back dependent is forwarded with no stall.
  - Load (lat=2): the dependent stalls exactly 1 cycle.
- Forwarding, purely combinational, per operand i:
  - src_reg[i] == 0: src_data = 0 and src_sel = 0, regardless of the stages.
  - Otherwise, find the lowest k with stage_wen[k] and stage_dest[k] == src_reg[i]. Then src_sel = k+1 and src_data = stage_data[k] (youngest wins).
  - If no stage matches: src_sel = 0 and src_data = src_rdat[i].
- Stall has no effect on forwarding; forwarded values are valid only when stall=0.
- stall_cycles increments on every edge with stall=1 and saturates at 0xFFFFFFFF. flush does not clear it.
- The block contains no internal pipeline registers; the only state is cnt[] and stall_cycles.

Test Plan:
1. Reset mid-operation: set cnt[3]=2 via a lat=3 issue, then assert RST asynchronously. Required: stall=0 immediately, all cnt=0, stall_cycles=0, and a following src_reg=3 read returns src_rdat.
2. Youngest-wins priority: stage_wen=3'b111, all stage_dest=7, stage_data={0x33,0x22,0x11}, src_reg[0]=7. Required: src_sel[0]=1 and src_data[0]=0x11. Then clear stage_wen[0]; required: src_sel[0]=2 and data 0x22.
3. Load-use stall: issue lw r5 with lat=2, next cycle src_reg[1]=5. Required: stall=1 and stall_src=2'b10 for exactly 1 cycle, then stall=0 and stall_cycles=1.
4. Multiply latency: issue mul r9 with lat=4, followed each cycle by a reader of r9. Required: 3 stalled cycles, then release. Same test with issue_lat=7 (clamped to 4): identical result. Same test with issue_lat=0: no stall.
5. WAW: issue r4 with lat=4, next cycle issue r4 with lat=1. Required: stall_waw=1 until cnt[4]=0, i.e. 3 stall cycles; cnt[4] is then reloaded with 0.
6. Register 0 and flush: src_reg=0 with stage_dest=0 and stage_wen=1 returns src_data=0 and sel=0. Issue r2 with lat=4 together with flush in the same cycle: required cnt[2]=0 afterwards and no stall on an r2 reader.

Source files
------------

// File: rtl/bypass_scoreboard.sv
// Operand bypass network with per-register pending-write scoreboard.
// Picks the youngest forwarded result per operand and stalls on RAW/WAW hazards.
module bypass_scoreboard #(
   parameter int NREAD  = 2,
   parameter int NSTAGE = 3,
   parameter int MAXLAT = 4,
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int LW     = $clog2(MAXLAT+1),
   parameter int SW     = $clog2(NSTAGE+1)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                issue_valid,
   input  logic                issue_wen,
   input  logic [AW-1:0]       issue_dest,
   input  logic [LW-1:0]       issue_lat,
   input  logic                flush,
   input  logic [NSTAGE-1:0]   stage_wen,
   input  logic [NSTAGE*AW-1:0] stage_dest,
   input  logic [NSTAGE*DW-1:0] stage_data,
   input  logic [NREAD*AW-1:0] src_reg,
   input  logic [NREAD*DW-1:0] src_rdat,
   output logic [NREAD*DW-1:0] src_data,
   output logic [NREAD*SW-1:0] src_sel,
   output logic                stall,
   output logic [NREAD-1:0]    stall_src,
   output logic                stall_waw,
   output logic [31:0]         stall_cycles
);

   localparam int NREG = 1 << AW;
   localparam logic [LW-1:0] MAXL = LW'(MAXLAT);

   logic [LW-1:0] cnt_q [NREG];
   logic [LW-1:0] cnt_d [NREG];
   logic [31:0]   stall_cycles_q, stall_cycles_d;
   logic [LW-1:0] eff_lat, eff_m1;
   logic          accept;

   always_comb begin
      eff_lat = issue_lat;
      if (issue_lat == '0)
         eff_lat = LW'(1);
      else if (issue_lat > MAXL)
         eff_lat = MAXL;
   end

   assign eff_m1 = eff_lat - LW'(1);

   // RAW checks the pre-update counters, so self-dependencies see the older producer
   always_comb begin
      for (int i = 0; i < NREAD; i++) begin
         stall_src[i] = (src_reg[i*AW +: AW] != '0) &&
                        (cnt_q[src_reg[i*AW +: AW]] != '0);
      end
   end

   assign stall_waw = issue_valid && issue_wen && (issue_dest != '0) &&
                      (cnt_q[issue_dest] > eff_m1);
   assign stall     = issue_valid && ((|stall_src) || stall_waw);
   assign accept    = issue_valid && !stall;

   for (genvar i = 0; i < NREAD; i++) begin : g_fwd
      logic [AW-1:0] r;
      logic [SW-1:0] sel;
      logic [DW-1:0] dat;

      assign r = src_reg[i*AW +: AW];

      // Scan oldest to youngest so the youngest match is the final assignment
      always_comb begin
         sel = '0;
         dat = src_rdat[i*DW +: DW];
         if (r == '0) begin
            dat = '0;
         end else begin
            for (int k = NSTAGE-1; k >= 0; k--) begin
               if (stage_wen[k] && (stage_dest[k*AW +: AW] == r)) begin
                  sel = SW'(k+1);
                  dat = stage_data[k*DW +: DW];
               end
            end
         end
      end

      assign src_sel[i*SW +: SW]  = sel;
      assign src_data[i*DW +: DW] = dat;
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (flush)
            cnt_d[r] = '0;
         else if (accept && issue_wen && (r != 0) && (issue_dest == AW'(r)))
            cnt_d[r] = eff_m1;
         else if (cnt_q[r] != '0)
            cnt_d[r] = cnt_q[r] - LW'(1);
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= '0;
         stall_cycles_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= cnt_d[r];
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule
